// File: rtl/disp_queue.sv
// In-order dispatch queue between decode and rename/dispatch.
// Accepts up to INPORT_NUM compacted entries per cycle and presents the OUTPORT_NUM oldest.

package disp_queue_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } decInfo_t;
endpackage

module disp_queue
    import disp_queue_pkg::*;
#(
    parameter  int DEPTH       = 8,
    parameter  int INPORT_NUM  = 4,
    parameter  int OUTPORT_NUM = 2,
    localparam int PW          = $clog2(DEPTH),
    localparam int CW          = PW + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_flush,
    input  logic     [INPORT_NUM-1:0]        i_enq_req,
    input  decInfo_t [INPORT_NUM-1:0]        i_enq_data,
    output logic                             o_can_enq,
    output logic     [OUTPORT_NUM-1:0]       o_deq_vld,
    output decInfo_t [OUTPORT_NUM-1:0]       o_deq_data,
    input  logic     [OUTPORT_NUM-1:0]       i_deq_req,
    output logic     [CW-1:0]                o_count
);

    decInfo_t        mem [DEPTH];
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [PW-1:0]   enq_ofs [INPORT_NUM];
    logic [CW-1:0]   enq_req_num;
    logic [CW-1:0]   enq_num;
    logic [CW-1:0]   deq_num;
    logic            enq_fire;

    // Requesting ports are packed towards tail in ascending port order.
    always_comb begin
        enq_req_num = '0;
        for (int i = 0; i < INPORT_NUM; i++) begin
            enq_ofs[i]  = enq_req_num[PW-1:0];
            enq_req_num = enq_req_num + CW'(i_enq_req[i]);
        end
        deq_num = '0;
        for (int k = 0; k < OUTPORT_NUM; k++) begin
            deq_num = deq_num + CW'(i_deq_req[k]);
        end
    end

    assign enq_fire = o_can_enq & ~i_flush;
    assign enq_num  = o_can_enq ? enq_req_num : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + deq_num[PW-1:0];
            tail  <= tail + enq_num[PW-1:0];
            count <= count + enq_num - deq_num;
        end
    end

    // Storage is never reset or cleared; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        for (int i = 0; i < INPORT_NUM; i++) begin
            if (enq_fire && i_enq_req[i]) begin
                mem[tail + enq_ofs[i]] <= i_enq_data[i];
            end
        end
    end

    assign o_count   = count;
    assign o_can_enq = (CW'(DEPTH) - count) >= CW'(INPORT_NUM);

    always_comb begin
        o_deq_vld  = '0;
        o_deq_data = '0;
        for (int k = 0; k < OUTPORT_NUM; k++) begin
            o_deq_vld[k]  = count > CW'(k);
            o_deq_data[k] = mem[head + PW'(k)];
        end
    end

    // Downstream must consume a contiguous prefix of the valid slots.
    always @(posedge clk) begin
        if (rst) begin
            assert (((i_deq_req + OUTPORT_NUM'(1)) & i_deq_req) == '0);
            assert ((i_deq_req & ~o_deq_vld) == '0);
        end
    end

endmodule

// File: doc/disp_queue.md
# disp_queue

In-order dispatch queue between the decode stage and the rename/dispatch stage. Each cycle it accepts up to INPORT_NUM decoded instructions (`decInfo_t`) from decode and presents up to OUTPORT_NUM of the oldest entries to the downstream stage. Entries are released in program order. A flush empties the queue for redirects.

## Interface
- DEPTH, 8: entry count; power of two, at least INPORT_NUM + OUTPORT_NUM.
- INPORT_NUM, 4: enqueue width (decode width).
- OUTPORT_NUM, 2: dequeue width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_flush  in  1  discard all entries.
- i_enq_req  in  INPORT_NUM  per-port enqueue request; holes allowed.
- i_enq_data  in  INPORT_NUM x decInfo_t  decoded instruction per port.
- o_can_enq  out  1  queue has at least INPORT_NUM free entries.
- o_deq_vld  out  OUTPORT_NUM  slot k holds a valid entry.
- o_deq_data  out  OUTPORT_NUM x decInfo_t  entry at head+k.
- i_deq_req  in  OUTPORT_NUM  downstream consumes slot k.
- o_count  out  clog2(DEPTH)+1  current occupancy.

## Operation
**State**
- Storage array of DEPTH `decInfo_t`.
- head and tail pointers, clog2(DEPTH) bits each; they wrap naturally modulo DEPTH.
- count register, clog2(DEPTH)+1 bits.

**Enqueue**
- Legal only when o_can_enq=1. Requests made while o_can_enq=0 are ignored.
- Requesting ports are compacted in ascending port order.
- The n-th requesting port (n from 0) is written to slot tail+n.
- tail and count advance by popcount(i_enq_req).

**Dequeue**
- o_deq_vld[k] = (count > k).
- o_deq_data[k] = storage[head+k], combinational from registered state. Contents are don't-care when o_deq_vld[k]=0.
- i_deq_req must be a prefix (bits 0..j set, the rest clear) and must be a subset of o_deq_vld. A violation fires a simulation assertion; RTL behaviour on violation is undefined.
- head advances by popcount(i_deq_req); count decrements by the same amount.

**Simultaneous enqueue and dequeue**
- count_next = count + enq_num - deq_num.
- Dequeue frees space only for the next cycle; o_can_enq is never raised combinationally by i_deq_req.

**o_can_enq**
- Equals (DEPTH - count) >= INPORT_NUM, from registered count.
- Conservative: the full INPORT_NUM is required even if fewer ports request.

**Flush**
- i_flush=1 sets head, tail and count to 0 at the next edge.
- Enqueue and dequeue in the same cycle are ignored; flush wins.
- Storage contents are not cleared.

**Reset**
- Asynchronous assertion: head=tail=count=0 immediately.
- Outputs during and after reset: o_deq_vld=0, o_count=0, o_can_enq=1.
- Reset mid-operation drops all entries.

## Timing
- Enqueue at edge t: the entry is visible on o_deq_vld/o_deq_data in the cycle after edge t (one-cycle latency).
- There is no same-cycle bypass from i_enq_data to o_deq_data.
- Dequeue handshake: the transfer occurs at the edge where o_deq_vld[k] and i_deq_req[k] are both 1.
- o_can_enq and o_count are pure functions of registered state; there is no combinational path from any input.
- o_deq_data depends only on registered state. There is no combinational path from i_deq_req or i_enq_* to outputs.
- Throughput at steady state: OUTPORT_NUM per cycle when the queue is non-empty. Enqueue proceeds every cycle while count <= DEPTH - INPORT_NUM.

## Test plan
All scenarios use DEPTH=8, INPORT_NUM=4, OUTPORT_NUM=2.

1. **Reset and single enqueue.** Release reset, then enqueue 4 entries (pc 0x100, 0x104, 0x108, 0x10c) with no dequeue.
   - Next cycle: o_count=4, o_deq_vld=2'b11, o_deq_data pcs 0x100/0x104, o_can_enq=1.
2. **Compaction with holes.** With the queue empty, i_enq_req=4'b1010 carrying pcs A (port1) and B (port3).
   - Next cycle: o_count=2, slot0=A, slot1=B.
3. **Fill and backpressure.** Enqueue 4, then 4 more with no dequeue.
   - o_count=8, o_can_enq=0.
   - A further 4'b1111 request is ignored; o_count stays 8.
   - Dequeue 2'b11 for two cycles: o_can_enq returns to 1 only after o_count=4.
4. **Wrap-around.** Run 20 cycles of enqueue 2 / dequeue 2 with incrementing pcs.
   - Dequeued pc sequence is strictly in order across head/tail wrap.
   - o_count constant at its initial value.
5. **Simultaneous events.** With count=4, in one cycle enqueue 4 and dequeue 2'b01.
   - Next cycle: o_count=7, o_can_enq=0.
   - Next, with count=3, assert i_flush together with enq 4'b1111 and deq 2'b11: following cycle o_count=0, o_deq_vld=0, o_can_enq=1.
6. **Reset mid-operation.** With count=5, drive rst low asynchronously between edges.
   - o_deq_vld=0 and o_count=0 before the next clock edge.
   - After release, the first enqueue appears at slot0.
